// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory bus arbiter and its helpers.
//   - FSM state encoding (ST_*)
//   - grant identifiers (GNT_*)
//   - clog2 / cnt_width helpers for sizing counters from a cycle limit
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_BUS_IF = 2'd1;
  localparam state_t ST_BUS_DM = 2'd2;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    if (n > 1) begin
      v = n - 1;
      while (v != 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

  // Width of a counter that must represent 0..limit, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Timeout counter for bus masters.
//   clk     : clock
//   srst    : synchronous active-high reset
//   clear   : forces the count back to zero (takes priority over enable)
//   enable  : counts one more elapsed cycle
//   expired : high while the count equals LIMIT-1, i.e. the current cycle is
//             the LIMIT-th enabled cycle; never asserted when LIMIT == 0
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW       = cnt_width(LIMIT);
  localparam int unsigned LAST_INT = (LIMIT == 0) ? 0 : LIMIT - 1;
  localparam logic [CW-1:0] LAST   = CW'(LAST_INT);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Saturate at LAST so a master that ignores expiry cannot wrap the count.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != LAST)) begin
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = (LIMIT != 0) && (count_reg == LAST);

endmodule

// File: rtl/mem_bus_arb.sv
// Arbiter for the single shared memory bus between instruction fetch (IF)
// and data memory (DM) ports. One transaction at a time is registered onto
// the bus; the bus acknowledge (or a timeout) returns a one-cycle ack with
// the captured read data to the granted port.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_if_req/i_if_addr           : fetch request, held until o_if_ack
//   o_if_data/o_if_ack           : fetched word, valid with one-cycle ack
//   i_dm_req/i_dm_we/i_dm_addr/i_dm_wdata : load/store request, held until o_dm_ack
//   o_dm_rdata/o_dm_ack          : load data, valid with one-cycle ack
//   o_err                        : pulses with the ack of a timed-out transaction
//   o_bus_req/o_bus_we/o_bus_addr/o_bus_data : registered bus command, frozen while active
//   i_bus_data/i_bus_ack         : bus read data and completion
module mem_bus_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned BUS_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_if_req,
  input  logic [BUS_ADDR_WIDTH-1:0] i_if_addr,
  output logic [BUS_DATA_WIDTH-1:0] o_if_data,
  output logic                      o_if_ack,
  input  logic                      i_dm_req,
  input  logic                      i_dm_we,
  input  logic [BUS_ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [BUS_DATA_WIDTH-1:0] i_dm_wdata,
  output logic [BUS_DATA_WIDTH-1:0] o_dm_rdata,
  output logic                      o_dm_ack,
  output logic                      o_err,
  output logic                      o_bus_req,
  output logic                      o_bus_we,
  output logic [BUS_ADDR_WIDTH-1:0] o_bus_addr,
  output logic [BUS_DATA_WIDTH-1:0] o_bus_data,
  input  logic [BUS_DATA_WIDTH-1:0] i_bus_data,
  input  logic                      i_bus_ack
);

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;

  logic                      bus_req_reg, bus_req_next;
  logic                      bus_we_reg, bus_we_next;
  logic [BUS_ADDR_WIDTH-1:0] bus_addr_reg, bus_addr_next;
  logic [BUS_DATA_WIDTH-1:0] bus_data_reg, bus_data_next;
  logic                      if_ack_reg, if_ack_next;
  logic                      dm_ack_reg, dm_ack_next;
  logic                      err_reg, err_next;
  logic [BUS_DATA_WIDTH-1:0] if_data_reg, if_data_next;
  logic [BUS_DATA_WIDTH-1:0] dm_rdata_reg, dm_rdata_next;

  logic eff_if, eff_dm, grant_valid, grant_sel;
  logic in_bus, tmr_expired, timeout, done;

  // A request still high during its own ack cycle is the one just served,
  // so it is masked for that cycle instead of being re-issued.
  assign eff_if      = i_if_req & ~if_ack_reg;
  assign eff_dm      = i_dm_req & ~dm_ack_reg;
  assign grant_valid = eff_if | eff_dm;
  // DM has priority, except that after a DM grant a contending IF goes next.
  assign grant_sel   = (eff_dm && !(eff_if && (last_grant_reg == GNT_DM))) ? GNT_DM : GNT_IF;

  assign in_bus  = (state_reg == ST_BUS_IF) || (state_reg == ST_BUS_DM);
  // A bus ack arriving in the expiry cycle wins over the timeout.
  assign timeout = in_bus & tmr_expired & ~i_bus_ack;
  assign done    = in_bus & (i_bus_ack | tmr_expired);

  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (i_clk),
    .srst    (i_rst),
    .clear   (~in_bus),
    .enable  (in_bus & ~i_bus_ack),
    .expired (tmr_expired)
  );

  // State register (also holds every registered output).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GNT_IF;
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= '0;
      bus_data_reg   <= '0;
      if_ack_reg     <= 1'b0;
      dm_ack_reg     <= 1'b0;
      err_reg        <= 1'b0;
      if_data_reg    <= '0;
      dm_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      bus_req_reg    <= bus_req_next;
      bus_we_reg     <= bus_we_next;
      bus_addr_reg   <= bus_addr_next;
      bus_data_reg   <= bus_data_next;
      if_ack_reg     <= if_ack_next;
      dm_ack_reg     <= dm_ack_next;
      err_reg        <= err_next;
      if_data_reg    <= if_data_next;
      dm_rdata_reg   <= dm_rdata_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          state_next      = (grant_sel == GNT_DM) ? ST_BUS_DM : ST_BUS_IF;
          last_grant_next = grant_sel;
        end
      end
      ST_BUS_IF, ST_BUS_DM: begin
        if (done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    bus_req_next  = bus_req_reg;
    bus_we_next   = bus_we_reg;
    bus_addr_next = bus_addr_reg;
    bus_data_next = bus_data_reg;
    if_ack_next   = 1'b0;
    dm_ack_next   = 1'b0;
    err_next      = 1'b0;
    if_data_next  = if_data_reg;
    dm_rdata_next = dm_rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          bus_req_next = 1'b1;
          if (grant_sel == GNT_DM) begin
            bus_we_next   = i_dm_we;
            bus_addr_next = i_dm_addr;
            bus_data_next = i_dm_wdata;
          end else begin
            bus_we_next   = 1'b0;
            bus_addr_next = i_if_addr;
            bus_data_next = '0;
          end
        end
      end
      ST_BUS_IF, ST_BUS_DM: begin
        if (done) begin
          bus_req_next  = 1'b0;
          bus_we_next   = 1'b0;
          bus_addr_next = '0;
          bus_data_next = '0;
          err_next      = timeout;
          if (state_reg == ST_BUS_IF) begin
            if_ack_next  = 1'b1;
            if_data_next = timeout ? '0 : i_bus_data;
          end else begin
            dm_ack_next   = 1'b1;
            dm_rdata_next = timeout ? '0 : i_bus_data;
          end
        end
      end
      default: begin
        bus_req_next  = 1'b0;
        bus_we_next   = 1'b0;
        bus_addr_next = '0;
        bus_data_next = '0;
        if_data_next  = '0;
        dm_rdata_next = '0;
      end
    endcase
  end

  assign o_bus_req  = bus_req_reg;
  assign o_bus_we   = bus_we_reg;
  assign o_bus_addr = bus_addr_reg;
  assign o_bus_data = bus_data_reg;
  assign o_if_ack   = if_ack_reg;
  assign o_dm_ack   = dm_ack_reg;
  assign o_err      = err_reg;
  assign o_if_data  = if_data_reg;
  assign o_dm_rdata = dm_rdata_reg;

endmodule
